// File: rtl/modbus_frame_tx_if.sv
// rtl/modbus_frame_tx_if.sv - buffer, control and uart byte handshake bundle for modbus_frame_tx
interface modbus_frame_tx_if #(
  parameter int MAX_LEN = 256
);
  localparam int AW = $clog2(MAX_LEN);

  logic          buf_wen;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic [AW:0]   frame_len;
  logic          crc_append;
  logic          start;
  logic          abort;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          busy;
  logic          frame_done;
  logic          aborted;
  logic          err_len;

  modport master (
    output buf_wen, buf_waddr, buf_wdata, frame_len, crc_append, start, abort, tx_done,
    input  tx_start, tx_data, busy, frame_done, aborted, err_len
  );

  modport slave (
    input  buf_wen, buf_waddr, buf_wdata, frame_len, crc_append, start, abort, tx_done,
    output tx_start, tx_data, busy, frame_done, aborted, err_len
  );
endinterface

// File: rtl/modbus_frame_tx.sv
// rtl/modbus_frame_tx.sv - Modbus RTU frame sender: buffered payload, optional CRC-16, 3.5-char gap
module modbus_frame_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_LEN   = 256,
  parameter int GAP_BITS  = 35,
  localparam int AW       = $clog2(MAX_LEN)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  modbus_frame_tx_if.slave bus
);
  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam logic [AW:0]   LEN_MAX  = (AW + 1)'(MAX_LEN);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT, S_CRC_LO, S_CRC_HI, S_GAP
  } state_t;

  state_t        state;
  logic [7:0]    mem [MAX_LEN];
  logic [7:0]    rdata;
  logic [AW:0]   len_q;
  logic [AW:0]   idx;
  logic          crc_en_q;
  logic          abort_req;
  logic          abort_now;
  logic [15:0]   crc;
  logic [15:0]   crc_next;
  logic [7:0]    crc_sh;
  logic [3:0]    crc_cnt;
  logic [GW-1:0] gap_cnt;

  assign abort_now = bus.abort | abort_req;

  // Buffer is frozen for the whole frame so a resend always sees what was loaded.
  always_ff @(posedge clk_in) begin
    if (bus.buf_wen && !bus.busy)
      mem[bus.buf_waddr] <= bus.buf_wdata;
    if (state == S_FETCH)
      rdata <= mem[idx[AW-1:0]];
  end

  always_comb begin
    crc_next = {1'b0, crc[15:1]};
    if (crc[0] ^ crc_sh[0])
      crc_next = crc_next ^ 16'hA001;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= S_IDLE;
      bus.tx_start   <= 1'b0;
      bus.tx_data    <= 8'h00;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.aborted    <= 1'b0;
      bus.err_len    <= 1'b0;
      len_q          <= '0;
      idx            <= '0;
      crc_en_q       <= 1'b0;
      abort_req      <= 1'b0;
      crc            <= 16'hFFFF;
      crc_sh         <= 8'h00;
      crc_cnt        <= 4'd0;
      gap_cnt        <= '0;
    end else begin
      bus.tx_start   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.aborted    <= 1'b0;
      bus.err_len    <= 1'b0;
      if (state != S_GAP)
        gap_cnt <= '0;
      // Bit-serial CRC fold, one payload bit per cycle after each tx_start.
      if (crc_cnt != 4'd0) begin
        crc     <= crc_next;
        crc_sh  <= {1'b0, crc_sh[7:1]};
        crc_cnt <= crc_cnt - 4'd1;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.frame_len == '0 || bus.frame_len > LEN_MAX) begin
              bus.err_len <= 1'b1;
            end else begin
              len_q     <= bus.frame_len;
              crc_en_q  <= bus.crc_append;
              crc       <= 16'hFFFF;
              idx       <= '0;
              abort_req <= 1'b0;
              bus.busy  <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (abort_now) begin
            abort_req <= 1'b1;
            state     <= S_GAP;
          end else begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          bus.tx_data  <= rdata;
          bus.tx_start <= 1'b1;
          crc_sh       <= rdata;
          crc_cnt      <= 4'd8;
          if (bus.abort)
            abort_req <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.abort)
            abort_req <= 1'b1;
          if (bus.tx_done) begin
            idx <= idx + 1'b1;
            if (abort_now) begin
              state <= S_GAP;
            end else if ((idx + 1'b1) < len_q) begin
              state <= S_FETCH;
            end else if (crc_en_q) begin
              bus.tx_data  <= crc[7:0];
              bus.tx_start <= 1'b1;
              state        <= S_CRC_LO;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_CRC_LO: begin
          if (bus.abort)
            abort_req <= 1'b1;
          if (bus.tx_done) begin
            if (abort_now) begin
              state <= S_GAP;
            end else begin
              bus.tx_data  <= crc[15:8];
              bus.tx_start <= 1'b1;
              state        <= S_CRC_HI;
            end
          end
        end
        S_CRC_HI: begin
          if (bus.abort)
            abort_req <= 1'b1;
          if (bus.tx_done)
            state <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            bus.busy <= 1'b0;
            if (abort_req)
              bus.aborted <= 1'b1;
            else
              bus.frame_done <= 1'b1;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modbus_frame_tx.sv
// tb/tb_modbus_frame_tx.sv - directed bench for modbus_frame_tx with a fixed-latency uart byte model
module tb_modbus_frame_tx;
  localparam int MAX_LEN  = 16;
  localparam int AW       = 4;
  localparam int GAP_CYC  = 350;
  localparam int UART_CYC = 20;

  typedef logic [7:0] bq_t [$];

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic uart_kill = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int cyc = 0, n_start = 0, n_done = 0, n_fd = 0, n_ab = 0, n_err = 0;
  int last_done_cyc = 0, fd_cyc = 0;
  logic [7:0] rx_q [$];

  always #5 clk_in = ~clk_in;

  modbus_frame_tx_if #(.MAX_LEN(MAX_LEN)) bus();

  modbus_frame_tx #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .MAX_LEN(MAX_LEN), .GAP_BITS(35)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .bus(bus)
  );

  initial forever begin
    @(negedge clk_in);
    cyc++;
    if (bus.tx_start) begin
      n_start++;
      rx_q.push_back(bus.tx_data);
    end
    if (bus.tx_done) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (bus.frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
    if (bus.aborted) n_ab++;
    if (bus.err_len) n_err++;
  end

  // UART byte model: tx_done a fixed number of cycles after each tx_start.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk_in);
      if (bus.tx_start && !uart_kill) begin
        for (int i = 0; i < UART_CYC; i++) begin
          @(posedge clk_in);
          if (uart_kill) break;
        end
        if (!uart_kill) begin
          #1 bus.tx_done = 1'b1;
          @(posedge clk_in);
          #1 bus.tx_done = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input bq_t b);
    foreach (b[i]) begin
      bus.buf_wen   = 1'b1;
      bus.buf_waddr = AW'(i);
      bus.buf_wdata = b[i];
      step();
    end
    bus.buf_wen = 1'b0;
  endtask

  task automatic pulse_start(input int len, input logic crc);
    bus.frame_len  = (AW + 1)'(len);
    bus.crc_append = crc;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int base;
    base = n_fd + n_ab;
    for (int i = 0; i < 3000 && (n_fd + n_ab) == base; i++) step();
    chk({tag, "_end_seen"}, n_fd + n_ab - base, 1);
    step();
  endtask

  task automatic check_frame(input string tag, input bq_t exp, input int rb);
    chk({tag, "_nbytes"}, rx_q.size() - rb, exp.size());
    foreach (exp[i])
      if (rb + i < rx_q.size())
        chk($sformatf("%s_b%0d", tag, i), rx_q[rb + i], exp[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_aborted"}, bus.aborted, 0);
    chk({tag, "_err_len"}, bus.err_len, 0);
  endtask

  initial begin
    bq_t f1, f2a, f2b, f3, e;
    int rb, bfd, bab, bst, bdn, ber;

    f1  = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01};
    f2a = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h05};
    f2b = '{8'h01, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04};
    f3  = '{8'h01, 8'h06, 8'h00, 8'h02, 8'h00, 8'h05, 8'hE8, 8'h09};
    bus.buf_wen = 0; bus.buf_waddr = '0; bus.buf_wdata = '0;
    bus.frame_len = '0; bus.crc_append = 0; bus.start = 0; bus.abort = 0;

    repeat (3) step();
    check_idle_outputs("reset");
    rst_n_in = 1'b1;
    step();

    // Read-holding request with CRC appended.
    load(f1);
    rb = rx_q.size(); bfd = n_fd; bab = n_ab;
    pulse_start(6, 1'b1);
    chk("t1_busy", bus.busy, 1);
    wait_end("t1");
    e = f1; e.push_back(8'hD5); e.push_back(8'hCA);
    check_frame("t1", e, rb);
    chk("t1_frame_done_cnt", n_fd - bfd, 1);
    chk("t1_aborted_cnt", n_ab - bab, 0);
    chk("t1_gap_ok", ((fd_cyc - last_done_cyc) >= GAP_CYC + 1 &&
                      (fd_cyc - last_done_cyc) <= GAP_CYC + 2), 1);
    chk("t1_busy_after", bus.busy, 0);

    load(f2a);
    rb = rx_q.size();
    pulse_start(6, 1'b1);
    wait_end("t2a");
    e = f2a; e.push_back(8'h18); e.push_back(8'h09);
    check_frame("t2a", e, rb);

    load(f2b);
    rb = rx_q.size();
    pulse_start(6, 1'b1);
    wait_end("t2b");
    e = f2b; e.push_back(8'hA0); e.push_back(8'h09);
    check_frame("t2b", e, rb);

    // Pre-built frame, CRC already in the payload.
    load(f3);
    rb = rx_q.size(); bfd = n_fd;
    pulse_start(8, 1'b0);
    wait_end("t3");
    check_frame("t3", f3, rb);
    chk("t3_frame_done_cnt", n_fd - bfd, 1);

    // Length rejects.
    bst = n_start; ber = n_err;
    pulse_start(0, 1'b1);
    step();
    chk("t4_err_len0", n_err - ber, 1);
    chk("t4_busy_len0", bus.busy, 0);
    pulse_start(MAX_LEN + 1, 1'b1);
    step();
    chk("t4_err_len17", n_err - ber, 2);
    chk("t4_busy_len17", bus.busy, 0);
    repeat (30) step();
    chk("t4_no_tx_start", n_start - bst, 0);

    // Abort during the third byte; a start in the gap is ignored.
    load(f1);
    rb = rx_q.size(); bfd = n_fd; bab = n_ab; bst = n_start; bdn = n_done;
    pulse_start(6, 1'b1);
    for (int i = 0; i < 1000 && (n_start - bst) < 3; i++) step();
    chk("t5_third_start", n_start - bst, 3);
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    for (int i = 0; i < 1000 && (n_done - bdn) < 3; i++) step();
    chk("t5_third_done", n_done - bdn, 3);
    repeat (5) step();
    pulse_start(6, 1'b1);
    wait_end("t5");
    e = '{8'h01, 8'h03, 8'h00};
    check_frame("t5", e, rb);
    chk("t5_aborted_cnt", n_ab - bab, 1);
    chk("t5_frame_done_cnt", n_fd - bfd, 0);
    repeat (30) step();
    chk("t5_no_more_start", n_start - bst, 3);
    chk("t5_busy_after", bus.busy, 0);

    // Reset mid-byte, then send with blocked writes, then resend.
    bst = n_start;
    pulse_start(6, 1'b1);
    for (int i = 0; i < 1000 && (n_start - bst) < 2; i++) step();
    repeat (5) step();
    uart_kill = 1'b1;
    rst_n_in = 1'b0;
    step();
    check_idle_outputs("t6_reset");
    rst_n_in = 1'b1;
    repeat (30) step();
    uart_kill = 1'b0;
    step();
    rb = rx_q.size(); bfd = n_fd; bab = n_ab;
    pulse_start(6, 1'b1);
    repeat (5) step();
    for (int i = 0; i < 6; i++) begin
      bus.buf_wen = 1'b1; bus.buf_waddr = AW'(i); bus.buf_wdata = 8'hFF;
      step();
    end
    bus.buf_wen = 1'b0;
    wait_end("t6a");
    e = f1; e.push_back(8'hD5); e.push_back(8'hCA);
    check_frame("t6a", e, rb);
    chk("t6a_frame_done_cnt", n_fd - bfd, 1);
    chk("t6a_aborted_cnt", n_ab - bab, 0);
    rb = rx_q.size();
    pulse_start(6, 1'b1);
    wait_end("t6b");
    check_frame("t6b", e, rb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
